mult_host: RTL and testbench

MULT_HOST -- requirements
Module: mult_host

---
 rtl/mult_host_if.sv | 22 ++
 rtl/mult_host.sv | 168 ++++++++++++++++
 tb/tb_mult_host.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_host_if.sv
// Host-to-multiplier bus: operand issue, fullness back-pressure and block readback.
interface mult_host_if #(
  parameter int N = 32
) ();
  logic         EN_mult;
  logic [15:0]  mult_input0;
  logic [15:0]  mult_input1;
  logic         RDY_mult;
  logic         EN_blockRead;
  logic         VALID_memVal;
  logic [N-1:0] memVal_data;

  modport master (
    output EN_mult, mult_input0, mult_input1, EN_blockRead,
    input  RDY_mult, VALID_memVal, memVal_data
  );

  modport slave (
    input  EN_mult, mult_input0, mult_input1, EN_blockRead,
    output RDY_mult, VALID_memVal, memVal_data
  );
endinterface

// File: rtl/mult_host.sv
// Block controller: feeds BLOCK operand pairs to a multiplier, reads the
// products back, forwards them downstream and accumulates their sum.
module mult_host #(
  parameter int N     = 32,
  parameter int BLOCK = 64
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          start,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [15:0]   op_a,
  input  logic [15:0]   op_b,
  mult_host_if.master   mbus,
  output logic          res_valid,
  output logic [N-1:0]  res_data,
  output logic [5:0]    res_idx,
  output logic [N-1:0]  block_sum,
  output logic          block_done,
  output logic          busy,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, REQ, COLLECT, DONE} state_e;

  localparam logic [6:0] BLOCK_C   = 7'(BLOCK);
  localparam logic [3:0] DRAIN_MAX = 4'd15;

  state_e         state_q, state_d;
  logic [6:0]     issue_cnt_q, issue_cnt_d;
  logic [6:0]     beat_cnt_q, beat_cnt_d;
  logic [3:0]     drain_cnt_q, drain_cnt_d;
  logic           en_mult_q, en_mult_d;
  logic [15:0]    in0_q, in0_d;
  logic [15:0]    in1_q, in1_d;
  logic           en_blockread_q, en_blockread_d;
  logic           res_valid_q, res_valid_d;
  logic [N-1:0]   res_data_q, res_data_d;
  logic [5:0]     res_idx_q, res_idx_d;
  logic [N-1:0]   block_sum_q, block_sum_d;
  logic           block_done_q, block_done_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           hs;
  logic           beat_ok;

  assign op_ready = rst_n && (state_q == ISSUE) && mbus.RDY_mult && (issue_cnt_q < BLOCK_C);
  assign hs       = op_valid && op_ready;
  assign beat_ok  = mbus.VALID_memVal && ((state_q == REQ) || (state_q == COLLECT));

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    en_mult_d    = 1'b0;
    in0_d        = in0_q;
    in1_d        = in1_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_idx_d    = res_idx_q;
    block_sum_d  = block_sum_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ISSUE;
          issue_cnt_d = '0;
          beat_cnt_d  = '0;
          block_sum_d = '0;
          err_d       = 1'b0;
        end
      end
      ISSUE: begin
        if (hs) begin
          en_mult_d   = 1'b1;
          in0_d       = op_a;
          in1_d       = op_b;
          issue_cnt_d = issue_cnt_q + 7'd1;
          if (issue_cnt_q + 7'd1 == BLOCK_C) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        // The multiplier signals "all products stored" by dropping RDY_mult.
        if (!mbus.RDY_mult) begin
          state_d = REQ;
        end else if (drain_cnt_q == DRAIN_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      REQ, COLLECT: begin
        if (beat_ok) begin
          res_valid_d = 1'b1;
          res_data_d  = mbus.memVal_data;
          res_idx_d   = beat_cnt_q[5:0];
          beat_cnt_d  = beat_cnt_q + 7'd1;
          block_sum_d = block_sum_q + mbus.memVal_data;
          state_d     = (beat_cnt_q + 7'd1 == BLOCK_C) ? DONE : COLLECT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Beats outside the readback window are dropped and flagged.
    if (mbus.VALID_memVal && !beat_ok) begin
      err_d = 1'b1;
    end

    busy_d         = (state_d != IDLE);
    en_blockread_d = (state_d == REQ);
    block_done_d   = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      issue_cnt_q    <= '0;
      beat_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      en_mult_q      <= 1'b0;
      in0_q          <= '0;
      in1_q          <= '0;
      en_blockread_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_idx_q      <= '0;
      block_sum_q    <= '0;
      block_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      issue_cnt_q    <= issue_cnt_d;
      beat_cnt_q     <= beat_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      en_mult_q      <= en_mult_d;
      in0_q          <= in0_d;
      in1_q          <= in1_d;
      en_blockread_q <= en_blockread_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_idx_q      <= res_idx_d;
      block_sum_q    <= block_sum_d;
      block_done_q   <= block_done_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign mbus.EN_mult      = en_mult_q;
  assign mbus.mult_input0  = in0_q;
  assign mbus.mult_input1  = in1_q;
  assign mbus.EN_blockRead = en_blockread_q;
  assign res_valid         = res_valid_q;
  assign res_data          = res_data_q;
  assign res_idx           = res_idx_q;
  assign block_sum         = block_sum_q;
  assign block_done        = block_done_q;
  assign busy              = busy_q;
  assign err               = err_q;
endmodule

// File: tb/tb_mult_host.sv
// Bench for mult_host: behavioural 64-deep multiplier plus result scoreboard.
module tb_mult_host;
  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a, op_b;
  logic        res_valid;
  logic [31:0] res_data;
  logic [5:0]  res_idx;
  logic [31:0] block_sum;
  logic        block_done;
  logic        busy;
  logic        err;

  mult_host_if #(.N(32)) mb ();

  mult_host #(.N(32), .BLOCK(64)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .mbus(mb), .res_valid(res_valid), .res_data(res_data),
    .res_idx(res_idx), .block_sum(block_sum), .block_done(block_done), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Multiplier model: stores up to 64 products, then streams them back on request.
  logic [31:0] pmem [64];
  int          wr_cnt, rd_cnt;
  logic        streaming, stub_valid, stub_force_rdy;
  logic [31:0] stub_data;
  logic        inj_valid;
  logic [31:0] inj_data;

  assign mb.RDY_mult     = stub_force_rdy || (wr_cnt < 64);
  assign mb.VALID_memVal = stub_valid || inj_valid;
  assign mb.memVal_data  = inj_valid ? inj_data : stub_data;

  always @(posedge CLK) begin
    if (!rst_n) begin
      wr_cnt <= 0; rd_cnt <= 0; streaming <= 1'b0; stub_valid <= 1'b0; stub_data <= '0;
    end else begin
      stub_valid <= 1'b0;
      if (mb.EN_mult && wr_cnt < 64) begin
        pmem[wr_cnt] <= 32'(mb.mult_input0) * 32'(mb.mult_input1);
        wr_cnt <= wr_cnt + 1;
      end
      if (!streaming && mb.EN_blockRead) begin
        streaming <= 1'b1;
        rd_cnt    <= 0;
      end
      if (streaming) begin
        stub_valid <= 1'b1;
        stub_data  <= pmem[rd_cnt];
        rd_cnt     <= rd_cnt + 1;
        if (rd_cnt == 63) begin
          streaming <= 1'b0;
          wr_cnt    <= 0;
        end
      end
    end
  end

  // Scoreboard queues and monitors.
  logic [31:0] pair_q [$];
  logic [37:0] exp_q [$];
  logic [31:0] exp_sum;
  int          en_mult_cnt = 0, res_cnt = 0, done_cnt = 0;
  logic        blockread_seen = 1'b0;
  logic [31:0] mon_p;
  logic [37:0] mon_e;

  always @(negedge CLK) begin
    if (rst_n) begin
      if (mb.EN_blockRead) blockread_seen = 1'b1;
      if (mb.EN_mult) begin
        en_mult_cnt++;
        chk("en_mult_has_pair", 32'(pair_q.size() > 0), 32'(1));
        if (pair_q.size() > 0) begin
          mon_p = pair_q.pop_front();
          chk("mult_input0", 32'(mb.mult_input0), 32'(mon_p[31:16]));
          chk("mult_input1", 32'(mb.mult_input1), 32'(mon_p[15:0]));
        end
      end
      if (res_valid) begin
        res_cnt++;
        chk("res_expected", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("res_data", res_data, mon_e[31:0]);
          chk("res_idx", 32'(res_idx), 32'(mon_e[37:32]));
        end
      end
      if (block_done) begin
        done_cnt++;
        chk("block_sum_at_done", block_sum, exp_sum);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'(0));
    chk({tag, "_en_mult"}, 32'(mb.EN_mult), 32'(0));
    chk({tag, "_mult_in"}, {mb.mult_input0, mb.mult_input1}, 32'(0));
    chk({tag, "_en_blockread"}, 32'(mb.EN_blockRead), 32'(0));
    chk({tag, "_res_valid"}, 32'(res_valid), 32'(0));
    chk({tag, "_res_data"}, res_data, 32'(0));
    chk({tag, "_res_idx"}, 32'(res_idx), 32'(0));
    chk({tag, "_block_sum"}, block_sum, 32'(0));
    chk({tag, "_block_done"}, 32'(block_done), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_err"}, 32'(err), 32'(0));
  endtask

  // Starts a block and offers 64 operand pairs; mode 0: (3i, i+1), 1: max, 2: random.
  task automatic run_issue(input int mode, input bit gaps, input int inj_at, input bit want_res);
    int          i = 0;
    int          cyc = 0;
    bit          injected = 1'b0;
    logic        v;
    logic [15:0] a, b;
    logic [31:0] prod;
    exp_sum = '0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));
    while (i < 64 && cyc < 3000) begin
      if (i == inj_at && !injected) begin
        op_valid  = 1'b0;
        inj_valid = 1'b1;
        inj_data  = 32'hDEAD_BEEF;
        @(negedge CLK);
        inj_valid = 1'b0;
        injected  = 1'b1;
        chk("spurious_err", 32'(err), 32'(1));
        chk("spurious_no_res", 32'(res_valid), 32'(0));
      end
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      case (mode)
        0:       begin a = 16'(i * 3); b = 16'(i + 1); end
        1:       begin a = 16'hFFFF;   b = 16'hFFFF;   end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      op_a = a; op_b = b; op_valid = v;
      if (v && op_ready) begin
        prod = 32'(a) * 32'(b);
        pair_q.push_back({a, b});
        if (want_res) begin
          exp_q.push_back({6'(i), prod});
          exp_sum = exp_sum + prod;
        end
        i++;
      end
      @(negedge CLK);
      cyc++;
    end
    op_valid = 1'b0;
    chk("all_operands_issued", 32'(i), 32'(64));
  endtask

  task automatic wait_done(input int d0);
    int cyc = 0;
    while (done_cnt == d0 && cyc < 400) begin
      @(negedge CLK);
      cyc++;
    end
    chk("block_done_seen", 32'(done_cnt - d0), 32'(1));
    repeat (3) @(negedge CLK);
    chk("single_done", 32'(done_cnt - d0), 32'(1));
    chk("busy_idle", 32'(busy), 32'(0));
  endtask

  int e0, r0, d0, n;

  initial begin
    rst_n = 1'b0; start = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0;
    inj_valid = 1'b0; inj_data = '0; stub_force_rdy = 1'b0; exp_sum = '0;
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge CLK);

    // Full block with the (3i, i+1) pattern.
    e0 = en_mult_cnt; r0 = res_cnt; d0 = done_cnt;
    run_issue(0, 1'b0, -1, 1'b1);
    wait_done(d0);
    chk("A_en_mult_cnt", 32'(en_mult_cnt - e0), 32'(64));
    chk("A_res_cnt", 32'(res_cnt - r0), 32'(64));
    chk("A_block_sum", block_sum, 32'd262080);
    chk("A_err", 32'(err), 32'(0));

    // Maximum operands: sum wraps modulo 2^32.
    r0 = res_cnt; d0 = done_cnt;
    run_issue(1, 1'b0, -1, 1'b1);
    wait_done(d0);
    chk("B_res_cnt", 32'(res_cnt - r0), 32'(64));
    chk("B_block_sum", block_sum, 32'hFF80_0040);

    // Random operands with upstream gaps.
    e0 = en_mult_cnt; r0 = res_cnt; d0 = done_cnt;
    run_issue(2, 1'b1, -1, 1'b1);
    wait_done(d0);
    chk("C_en_mult_cnt", 32'(en_mult_cnt - e0), 32'(64));
    chk("C_res_cnt", 32'(res_cnt - r0), 32'(64));
    repeat (5) @(negedge CLK);
    chk("C_sum_stable", block_sum, exp_sum);

    // Spurious readback beat during ISSUE.
    e0 = en_mult_cnt; r0 = res_cnt; d0 = done_cnt;
    run_issue(0, 1'b0, 10, 1'b1);
    wait_done(d0);
    chk("D_en_mult_cnt", 32'(en_mult_cnt - e0), 32'(64));
    chk("D_res_cnt", 32'(res_cnt - r0), 32'(64));
    chk("D_err_sticky", 32'(err), 32'(1));

    // Multiplier never fills: drain timeout.
    stub_force_rdy = 1'b1;
    blockread_seen = 1'b0;
    d0 = done_cnt;
    run_issue(0, 1'b0, -1, 1'b0);
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("E_timeout_cycles", 32'(n), 32'(16));
    chk("E_busy", 32'(busy), 32'(0));
    repeat (4) @(negedge CLK);
    chk("E_no_blockread", 32'(blockread_seen), 32'(0));
    chk("E_no_done", 32'(done_cnt - d0), 32'(0));
    stub_force_rdy = 1'b0;
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);

    // Reset in the middle of readback, then a clean block.
    r0 = res_cnt;
    run_issue(0, 1'b0, -1, 1'b1);
    n = 0;
    while (res_cnt - r0 < 30 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("F_reached_beat30", 32'(res_cnt - r0 >= 30), 32'(1));
    rst_n = 1'b0;
    @(negedge CLK);
    check_reset_vals("F_midreset");
    rst_n = 1'b1;
    exp_q.delete();
    pair_q.delete();
    r0 = res_cnt; d0 = done_cnt;
    repeat (80) @(negedge CLK);
    chk("F_no_res_after_reset", 32'(res_cnt - r0), 32'(0));
    chk("F_no_done_after_reset", 32'(done_cnt - d0), 32'(0));
    e0 = en_mult_cnt; r0 = res_cnt;
    run_issue(0, 1'b0, -1, 1'b1);
    wait_done(d0);
    chk("F_en_mult_cnt", 32'(en_mult_cnt - e0), 32'(64));
    chk("F_res_cnt", 32'(res_cnt - r0), 32'(64));
    chk("F_block_sum", block_sum, 32'd262080);
    chk("F_err", 32'(err), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
